hs32_scoreboard: RTL and testbench

- Register scoreboard and interlock controller for the decode2 stage.
- Tracks in-flight destination registers from issue until writeback, counting down each producer's result latency.
- Per issuing instruction, decides: read the register file, forward the stage-3 result, or stall.
- Drives decode2's stall and forward-select inputs, and gates the issue handshake toward execute.

---
 rtl/hs32_scoreboard_pkg.sv | 10 +
 rtl/hs32_sb_slot.sv | 41 ++++
 rtl/hs32_scoreboard.sv | 69 ++++++
 tb/tb_hs32_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hs32_scoreboard_pkg.sv
// Shared types and defaults for the hs32 decode2 register scoreboard.
package hs32_scoreboard_pkg;
  localparam int HS32_NREG    = 16;
  localparam int HS32_SB_LATW = 2;

  typedef struct packed {
    logic                    busy;
    logic [HS32_SB_LATW-1:0] cnt;
  } hs32_sb_entry;
endpackage

// File: rtl/hs32_sb_slot.sv
// One scoreboard entry: busy bit plus remaining-latency countdown.
// Priority: reset > flush > issue set > writeback clear > decrement.
module hs32_sb_slot
  import hs32_scoreboard_pkg::*;
#(
  parameter int LATW = HS32_SB_LATW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_set,
  input  logic [LATW-1:0] i_lat,
  input  logic            i_clr,
  output logic            o_busy,
  output logic [LATW-1:0] o_cnt
);
  logic            r_busy;
  logic [LATW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_cnt  <= i_lat;
    end else if (i_clr) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy && (r_cnt != '0)) begin
      // Reaching zero means the result sits on the forward bus until writeback.
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/hs32_scoreboard.sv
// Decode2 register scoreboard: RAW/WAW interlock, stage-3 forward select, issue gating.
// Optional stall-cycle counter enabled by defining HS32_SCOREBOARD_STATS_EN.
module hs32_scoreboard
  import hs32_scoreboard_pkg::*;
#(
  parameter int NREG = HS32_NREG,
  parameter int LATW = HS32_SB_LATW,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid_i,
  input  logic [IW-1:0]   iss_rm_i,
  input  logic [IW-1:0]   iss_rd_i,
  input  logic            iss_we_i,
  input  logic [LATW-1:0] iss_lat_i,
  output logic            iss_fire_o,
  output logic            stall_o,
  output logic            fwd_o,
  input  logic            wb_valid_i,
  input  logic [IW-1:0]   wb_rd_i,
  input  logic            flush_i,
`ifdef HS32_SCOREBOARD_STATS_EN
  input  logic            stat_clr_i,
  output logic [31:0]     stall_cnt_o,
`endif
  output logic [NREG-1:0] busy_o
);
  logic [NREG-1:0]           w_busy;
  logic [NREG-1:0][LATW-1:0] w_cnt;
  logic                      w_raw;
  logic                      w_waw;
  logic                      w_live;

  for (genvar g = 0; g < NREG; g++) begin : g_slot
    hs32_sb_slot #(.LATW(LATW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush_i),
      .i_set   (iss_fire_o && iss_we_i && (iss_rd_i == IW'(g))),
      .i_lat   (iss_lat_i),
      .i_clr   (wb_valid_i && (wb_rd_i == IW'(g))),
      .o_busy  (w_busy[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  // A flush kills the issuing instruction too, so nothing is stalled or forwarded.
  assign w_live     = iss_valid_i && !flush_i;
  assign w_raw      = w_busy[iss_rm_i] && (w_cnt[iss_rm_i] != '0);
  assign w_waw      = iss_we_i && w_busy[iss_rd_i] && (w_cnt[iss_rd_i] > iss_lat_i);
  assign stall_o    = w_live && (w_raw || w_waw);
  assign fwd_o      = w_live && w_busy[iss_rm_i] && (w_cnt[iss_rm_i] == '0) && !stall_o;
  assign iss_fire_o = w_live && !stall_o;
  assign busy_o     = w_busy;

`ifdef HS32_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr_i)
      r_stall_cnt <= '0;
    else if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hs32_scoreboard.sv
// Self-checking bench for hs32_scoreboard: directed hazards plus random traffic vs a ready-time model.
module tb_hs32_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid_i;
  logic [3:0]  iss_rm_i;
  logic [3:0]  iss_rd_i;
  logic        iss_we_i;
  logic [1:0]  iss_lat_i;
  logic        iss_fire_o;
  logic        stall_o;
  logic        fwd_o;
  logic        wb_valid_i;
  logic [3:0]  wb_rd_i;
  logic        flush_i;
  logic [15:0] busy_o;
`ifdef HS32_SCOREBOARD_STATS_EN
  logic        stat_clr_i;
  logic [31:0] stall_cnt_o;
  longint      mstat = 0;
`endif

  always #5 clk = ~clk;

  hs32_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (iss_valid_i),
    .iss_rm_i    (iss_rm_i),
    .iss_rd_i    (iss_rd_i),
    .iss_we_i    (iss_we_i),
    .iss_lat_i   (iss_lat_i),
    .iss_fire_o  (iss_fire_o),
    .stall_o     (stall_o),
    .fwd_o       (fwd_o),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .flush_i     (flush_i),
`ifdef HS32_SCOREBOARD_STATS_EN
    .stat_clr_i  (stat_clr_i),
    .stall_cnt_o (stall_cnt_o),
`endif
    .busy_o      (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: each pending register remembers the absolute cycle its result appears.
  bit     mbusy [16];
  longint mrdy  [16];
  longint now = 0;

  logic        s_stall, s_fwd, s_fire;
  logic [15:0] s_busy;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", nm, act, exp, now);
    end
  endtask

  function automatic longint mcnt(input int r);
    longint d = mrdy[r] - now;
    return (d > 0) ? d : 0;
  endfunction

  task automatic cyc(input bit rs, input bit v, input int rm, input int rd, input bit we,
                     input int lat, input bit wbv, input int wbrd, input bit fl, input bit sc);
    bit          e_st, e_fw, e_fi;
    logic [15:0] e_busy;
    rst_n = rs; iss_valid_i = v; iss_rm_i = rm[3:0]; iss_rd_i = rd[3:0];
    iss_we_i = we; iss_lat_i = lat[1:0]; wb_valid_i = wbv; wb_rd_i = wbrd[3:0]; flush_i = fl;
`ifdef HS32_SCOREBOARD_STATS_EN
    stat_clr_i = sc;
`endif
    #4;
    e_st = v && !fl && ((mbusy[rm] && mcnt(rm) != 0) || (we && mbusy[rd] && mcnt(rd) > lat));
    e_fw = v && !fl && mbusy[rm] && (mcnt(rm) == 0) && !e_st;
    e_fi = v && !fl && !e_st;
    for (int r = 0; r < 16; r++) e_busy[r] = mbusy[r];
    s_stall = stall_o; s_fwd = fwd_o; s_fire = iss_fire_o; s_busy = busy_o;
    chk("stall", s_stall, e_st);
    chk("fwd",   s_fwd,   e_fw);
    chk("fire",  s_fire,  e_fi);
    chk("busy",  s_busy,  e_busy);
`ifdef HS32_SCOREBOARD_STATS_EN
    chk("stall_cnt", stall_cnt_o, mstat);
    if (!rs || sc) mstat = 0;
    else if (e_st && mstat != 64'hFFFF_FFFF) mstat++;
`else
    if (sc) checks = checks + 0;
`endif
    if (!rs || fl) begin
      for (int r = 0; r < 16; r++) mbusy[r] = 0;
    end else begin
      if (wbv) mbusy[wbrd] = 0;
      if (e_fi && we) begin
        mbusy[rd] = 1;
        mrdy[rd]  = now + 1 + lat;
      end
    end
    @(posedge clk); #1;
    now++;
  endtask

  task automatic iss(input int rm, input int rd, input bit we, input int lat);
    cyc(1, 1, rm, rd, we, lat, 0, 0, 0, 0);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    // Reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    iss(0, 0, 0, 0);
    chk("rst_busy", s_busy, 0); chk("rst_stall", s_stall, 0);
    chk("rst_fwd", s_fwd, 0);   chk("rst_fire", s_fire, 1);

    // Single-cycle producer forwards, also during its writeback cycle
    iss(0, 3, 1, 0);
    chk("r3_fire", s_fire, 1);
    iss(3, 0, 0, 0);
    chk("r3_fwd", s_fwd, 1); chk("r3_stall", s_stall, 0);
    cyc(1, 1, 3, 0, 0, 0, 1, 3, 0, 0);
    chk("r3_fwd_wb", s_fwd, 1);
    idle();
    chk("r3_retired", s_busy[3], 0);

    // Latency-2 producer: consumer stalls while cnt is 2 then 1, forwards at 0
    iss(0, 5, 1, 2);
    iss(5, 0, 0, 0); chk("r5_stall_a", s_stall, 1);
    iss(5, 0, 0, 0); chk("r5_stall_b", s_stall, 1);
    iss(5, 0, 0, 0); chk("r5_fwd", s_fwd, 1); chk("r5_nostall", s_stall, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 5, 0, 0);

    // WAW: lat-0 write to r7 waits for the lat-3 write to drain
    iss(0, 7, 1, 3);
    n = 0;
    iss(0, 7, 1, 0);
    while (!s_fire && n < 10) begin
      n++;
      iss(0, 7, 1, 0);
    end
    chk("waw_stalls", n, 3);
    idle();
    chk("waw_busy7", s_busy[7], 1);

    // Same-cycle writeback and issue to r2: issue wins with cnt=1
    iss(0, 2, 1, 0);
    cyc(1, 1, 0, 2, 1, 1, 1, 2, 0, 0);
    chk("r2_fire", s_fire, 1);
    iss(2, 0, 0, 0);
    chk("r2_busy", s_busy[2], 1); chk("r2_stall", s_stall, 1);

    // Flush with an issuing instruction
    iss(0, 1, 1, 3); iss(0, 4, 1, 3); iss(0, 9, 1, 3);
    cyc(1, 1, 1, 6, 1, 0, 0, 0, 1, 0);
    chk("fl_fire", s_fire, 0); chk("fl_stall", s_stall, 0);
    idle();
    chk("fl_busy", s_busy, 0);

`ifdef HS32_SCOREBOARD_STATS_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    iss(0, 5, 1, 3);
    iss(5, 0, 0, 0); iss(5, 0, 0, 0); iss(5, 0, 0, 0);
    idle();
    chk("stat_three", stall_cnt_o, 3);
    cyc(1, 0, 0, 0, 0, 0, 1, 5, 0, 1);
    idle();
    chk("stat_clr", stall_cnt_o, 0);
`endif

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 200) != 0, ($urandom % 10) < 7,
          int'($urandom % 6), int'($urandom % 6), ($urandom % 10) < 7, int'($urandom % 4),
          ($urandom % 4) == 0, int'($urandom % 6), ($urandom % 40) == 0, ($urandom % 60) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
